// File: rtl/usb_rx_data_buffer.sv
// Receive-side byte FIFO between usb_rx and the AHB-lite slave.
// First-word fall-through head, occupancy counter, sticky overrun/underrun.
module usb_rx_data_buffer #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8,
    parameter int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             clear,
    input  logic             store_rx_packet_data,
    input  logic [WIDTH-1:0] rx_packet_data,
    input  logic             get_rx_data,
    output logic [WIDTH-1:0] rx_data,
    output logic [OCC_W-1:0] buffer_occupancy,
    output logic             buffer_empty,
    output logic             buffer_full,
    output logic             overrun,
    output logic             underrun
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             overrun_q;
    logic             underrun_q;
    logic             wr_en;
    logic             rd_en;
    logic             empty;
    logic             full;

    assign empty = (occ == '0);
    assign full  = (occ == OCC_W'(DEPTH));

    // A pop in the same cycle frees the slot a full-buffer write lands in.
    assign rd_en = get_rx_data && !empty;
    assign wr_en = store_rx_packet_data && (!full || rd_en);

    // NOTE: the array is cleared only by rst; flush/clear just rewind the
    // pointers, so the storage needs no per-entry reset on the flush path.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush || clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= rx_packet_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({wr_en, rd_en})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            if (store_rx_packet_data && !wr_en) begin
                overrun_q <= 1'b1;
            end
            if (get_rx_data && empty) begin
                underrun_q <= 1'b1;
            end
        end
    end

    assign rx_data          = empty ? '0 : mem[rd_ptr];
    assign buffer_occupancy = occ;
    assign buffer_empty     = empty;
    assign buffer_full      = full;
    assign overrun          = overrun_q;
    assign underrun         = underrun_q;

endmodule
